// File: rtl/index_sequencer.sv
// Purpose : 3-bit index sequencer (mod 8, up/down) that auto-advances on a prescaler tick while running, or steps on a button edge while stopped.
// Latency : idx/adv/wrap update 1 clk after a tick; step_btn rising edge reaches idx after 3 clks (2-flop sync + edge register).
// Backpres: none; step edges seen while running are dropped, never queued.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_run       1 = auto-advance on prescaler tick, 0 = stopped (manual stepping)
//   i_dir       0 = increment, 1 = decrement (sampled in the advancing cycle)
//   i_step_btn  asynchronous push-button
//   o_idx       registered current index (drives 3-to-8 decoder)
//   o_adv       one-clock pulse in the cycle o_idx first shows a new value
//   o_wrap      one-clock pulse with o_adv on 7->0 (inc) or 0->7 (dec)
module index_sequencer #(
    parameter int unsigned DIV_MAX = 49999,
    parameter int unsigned DIV_W   = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    input  logic       i_dir,
    input  logic       i_step_btn,
    output logic [2:0] o_idx,
    output logic       o_adv,
    output logic       o_wrap
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] C_DIV_MAX = DIV_W'(DIV_MAX);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] w_presc_nxt;
    logic             w_tick;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             r_step;
    logic             w_step_edge;
    logic             w_step_adv;

    logic             w_adv;
    logic             w_wrap;
    logic [2:0]       w_idx_nxt;
    logic [2:0]       r_idx;
    logic             r_adv;
    logic             r_wrap;

    // State and prescaler register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_STOP;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    // Prescaler only counts while staying in RUN; any entry into or exit from
    // RUN leaves it at 0, so a restart always waits a full period. A tick that
    // is already raised in the cycle run drops is still honoured.
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = '0;
        w_tick      = 1'b0;
        case (r_state)
            ST_STOP: begin
                if (i_run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_tick = (r_presc == C_DIV_MAX);
                if (!i_run) begin
                    w_state_nxt = ST_STOP;
                end else if (!w_tick) begin
                    w_presc_nxt = r_presc + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    // Button synchronizer, previous-value flop and registered edge pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            r_sync1 <= i_step_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_step  <= w_step_edge;
        end
    end

    assign w_step_edge = r_sync2 & ~r_prev;

    // A step only counts when fully stopped; otherwise it is simply lost.
    assign w_step_adv = r_step & (r_state == ST_STOP) & ~i_run;

    // Tick only exists in RUN and steps only in STOP, so they never collide.
    assign w_adv     = w_tick | w_step_adv;
    assign w_idx_nxt = i_dir ? (r_idx - 3'd1) : (r_idx + 3'd1);
    assign w_wrap    = i_dir ? (r_idx == 3'd0) : (r_idx == 3'd7);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx  <= 3'd0;
            r_adv  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_adv  <= w_adv;
            r_wrap <= w_adv & w_wrap;
            if (w_adv) begin
                r_idx <= w_idx_nxt;
            end
        end
    end

    assign o_idx  = r_idx;
    assign o_adv  = r_adv;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_index_sequencer.sv
// Testbench for index_sequencer with DIV_MAX=3: expected advances are predicted
// per clock edge from run/step history and queued; a monitor on the falling
// edge pops and compares them whenever the DUT should or does advance.
module tb_index_sequencer;

    localparam int DIV_MAX = 3;
    localparam int PERIOD  = DIV_MAX + 1;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       run      = 1'b0;
    logic       dir      = 1'b0;
    logic       step_btn = 1'b0;
    logic [2:0] idx;
    logic       adv;
    logic       wrap;

    index_sequencer #(
        .DIV_MAX (DIV_MAX),
        .DIV_W   (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_run      (run),
        .i_dir      (dir),
        .i_step_btn (step_btn),
        .o_idx      (idx),
        .o_adv      (adv),
        .o_wrap     (wrap)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         cyc;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: length of the current run-high streak of sampled
    // edges, run level at the previous edge, last four sampled button levels.
    int       m_streak   = 0;
    bit       m_run_prev = 1'b0;
    bit [4:1] m_bh       = '0;
    int       m_idx      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        m_streak   = 0;
        m_run_prev = 1'b0;
        m_bh       = '0;
        m_idx      = 0;
        sb.delete();
    endtask

    // Predict the effect of the coming rising edge given the inputs it samples.
    task automatic model_edge(input bit r, input bit d, input bit b);
        bit   tick_adv;
        bit   step_adv;
        bit   wr;
        exp_t e;
        tick_adv = m_run_prev && (m_streak > 0) && (m_streak % PERIOD == 0);
        step_adv = m_bh[3] && !m_bh[4] && !m_run_prev && !r;
        if (tick_adv || step_adv) begin
            wr     = d ? (m_idx == 0) : (m_idx == 7);
            m_idx  = d ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
            e.cyc  = edge_cnt + 1;
            e.idx  = 3'(m_idx);
            e.wrap = wr;
            sb.push_back(e);
        end
        m_streak   = r ? m_streak + 1 : 0;
        m_run_prev = r;
        m_bh       = {m_bh[3:1], b};
    endtask

    // Called at a falling edge; applies inputs for one rising edge and
    // returns at the following falling edge.
    task automatic drive(input bit r, input bit d, input bit b, input bit rn);
        #1;
        rst_n    = rn;
        run      = r;
        dir      = d;
        step_btn = b;
        if (!rn) model_reset();
        else     model_edge(r, d, b);
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n, input bit r, input bit d, input bit b);
        for (int i = 0; i < n; i++) drive(r, d, b, 1'b1);
    endtask

    // Assert reset between clock edges and confirm it acts without a clock.
    task automatic reset_async(input bit b);
        #1;
        rst_n    = 1'b0;
        run      = 1'b0;
        step_btn = b;
        model_reset();
        #1;
        check("async_rst_idx", idx, 0);
        check("async_rst_adv", adv, 0);
        check("async_rst_wrap", wrap, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, b, 1'b0);
    endtask

    logic [2:0] mon_idx = '0;

    always @(negedge clk) begin
        bit   exp_here;
        exp_t e;
        if (!rst_n) begin
            check("rst_idx", idx, 0);
            check("rst_adv", adv, 0);
            check("rst_wrap", wrap, 0);
            mon_idx = '0;
        end else begin
            exp_here = (sb.size() > 0) && (sb[0].cyc == edge_cnt);
            check("adv", adv, exp_here);
            if (exp_here) begin
                e = sb.pop_front();
                check("idx_adv", idx, e.idx);
                check("wrap", wrap, e.wrap);
                mon_idx = e.idx;
            end else begin
                check("idx_hold", idx, mon_idx);
                check("wrap_idle", wrap, 0);
            end
        end
    end

    initial begin
        bit r;
        bit d;
        bit b;
        #1 rst_n = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Auto-increment for 40 clocks: advances at RUN+4, +8, ... +36.
        run_cycles(40, 1'b1, 1'b0, 1'b0);
        check("run40_idx", idx, 1);

        // Decrement from 0: first advance is 0->7 with wrap.
        reset_async(1'b0);
        run_cycles(5, 1'b1, 1'b1, 1'b0);
        check("dec_first_idx", idx, 7);
        check("dec_first_adv", adv, 1);
        check("dec_first_wrap", wrap, 1);
        run_cycles(12, 1'b1, 1'b1, 1'b0);

        // Manual stepping: three 5-high/5-low pulses.
        reset_async(1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            run_cycles(5, 1'b0, 1'b0, 1'b1);
            run_cycles(5, 1'b0, 1'b0, 1'b0);
        end
        check("step3_idx", idx, 3);

        // Button pulses while running are dropped.
        for (int i = 0; i < 36; i++) drive(1'b1, 1'b0, 1'((i / 3) % 2), 1'b1);

        // Reset mid-count with idx=5 and prescaler at 2.
        reset_async(1'b0);
        run_cycles(23, 1'b1, 1'b0, 1'b0);
        check("pre_rst_idx", idx, 5);
        reset_async(1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        run_cycles(9, 1'b1, 1'b0, 1'b0);

        // Run dropped 2 clocks before a tick, then re-entered.
        run_cycles(2, 1'b1, 1'b0, 1'b0);
        run_cycles(1, 1'b0, 1'b0, 1'b0);
        run_cycles(9, 1'b1, 1'b0, 1'b0);

        // Fast run toggling never advances.
        for (int i = 0; i < 24; i++) drive(1'(i % 2), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) drive(1'((i / 3) % 2), 1'b1, 1'b0, 1'b1);

        // Button held through reset release: exactly one step.
        reset_async(1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        run_cycles(8, 1'b0, 1'b0, 1'b1);
        check("btn_thru_rst_idx", idx, 1);
        run_cycles(4, 1'b0, 1'b0, 1'b0);

        // Random traffic, including occasional mid-operation resets.
        r = 1'b0;
        d = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(11) == 0) r = ~r;
            if ($urandom_range(7) == 0)  d = ~d;
            if ($urandom_range(3) == 0)  b = ~b;
            if ($urandom_range(599) == 0) begin
                reset_async(b);
                drive(1'b0, d, b, 1'b0);
            end else begin
                drive(r, d, b, 1'b1);
            end
        end

        run_cycles(10, 1'b0, 1'b0, 1'b0);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/index_sequencer.md
INDEX_SEQUENCER -- requirements
Module: index_sequencer

Interface
REQ-001 DIV_MAX, default 49999, prescaler terminal count; the auto-advance period is DIV_MAX+1 clocks.
REQ-002 DIV_W, default 16, prescaler width; DIV_MAX < 2^DIV_W.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 = auto-advance on prescaler tick, 0 = stopped (manual stepping).
REQ-006 dir  input  1  0 = increment, 1 = decrement.
REQ-007 step_btn  input  1  asynchronous push-button; each rising edge advances one position while stopped.
REQ-008 idx  output  3  registered current index; drives the 3-to-8 decoder input directly.
REQ-009 adv  output  1  registered one-clock pulse, high in the cycle idx first shows its new value.
REQ-010 wrap  output  1  registered one-clock pulse, coincident with adv, when idx went 7->0 (inc) or 0->7 (dec).

Function
REQ-011 FSM has two states, STOP and RUN; STOP->RUN on an edge with run=1; RUN->STOP on an edge with run=0.
REQ-012 Prescaler: holds 0 in STOP; in RUN increments every clock; at DIV_MAX returns to 0 and raises internal tick for that cycle only.
REQ-013 On every STOP->RUN transition the prescaler starts from 0, so the first auto-advance lands DIV_MAX+1 clocks after the state becomes RUN.
REQ-014 On RUN->STOP the prescaler clears to 0 and any pending count is discarded; idx holds.
REQ-015 Tick at edge N -> idx, adv and wrap update at edge N+1.
REQ-016 step_btn path: two-flop synchronizer, then a prev flop; an edge is sync2 & ~prev.
REQ-017 Step latency: step_btn high before edge k -> idx changes at edge k+3, with adv high in the same cycle.
REQ-018 A detected step edge advances idx only if the state is STOP and run=0 in that cycle; otherwise it is dropped, never queued.
REQ-019 Holding step_btn high produces exactly one advance; a further advance requires a low level of at least 1 synchronized cycle, then high.
REQ-020 Advance arithmetic is modulo 8: inc gives idx+1 and 7->0; dec gives idx-1 and 0->7.
REQ-021 dir is sampled in the advancing cycle; a dir change in RUN takes effect at the next advance without resetting the prescaler.
REQ-022 adv and wrap are 0 in every cycle with no advance; wrap=1 implies adv=1.
REQ-023 run toggling more often than DIV_MAX+1 clocks yields no advances and no adv/wrap pulses.

Reset
REQ-024 rst_n=0 immediately, independent of clk, forces: idx=0, adv=0, wrap=0, state STOP, prescaler 0, synchronizer and prev flops 0.
REQ-025 Reset mid-count or mid-step aborts the operation; after release the block behaves as if freshly reset, with no stale tick or step.
REQ-026 If step_btn is high through reset release, exactly one step occurs, 3 clocks after release, provided run=0.
REQ-027 rst_n assertion and release are synchronous to clk in the bench; release timing is not otherwise constrained inside the block.

Verification (DIV_MAX=3)
REQ-028 Reset, then run=1, dir=0 for 40 clocks -> idx goes 0,1,...,7,0,1 with one change every 4 clocks; the first change comes 4 clocks after RUN is entered; wrap pulses once, at 7->0.
REQ-029 run=1, dir=1 from idx=0 -> next idx=7 with adv=1 and wrap=1 in the same cycle, then 6, 5.
REQ-030 run=0, three step_btn pulses (each 5 clocks high, 5 clocks low) -> idx 0->1->2->3; each change is 3 clocks after the rising input, with one adv per pulse.
REQ-031 run=1, step_btn pulsed -> no extra advance; idx changes only on tick.
REQ-032 rst_n asserted between clock edges while idx=5 and the prescaler is at 2 -> idx=0, adv=0 immediately; after release with run=1 the first advance comes 4 clocks after RUN.
REQ-033 run deasserted 2 clocks before a tick, then reasserted -> no advance at the old tick; the next advance is 4 clocks after RUN is re-entered.
